regfile_port_scheduler: RTL and testbench

Single-port scheduler in front of the 32x32 register file, whose port performs either one write or one dual read per clock. It arbitrates between the decode-stage read requester and the writeback-stage write requester. Pending writes are held in a small FIFO. Reads forward from that FIFO, so decode always sees the newest value of a register.

---
 rtl/regfile_port_scheduler.sv | 162 ++++++++++++++++
 tb/tb_regfile_port_scheduler.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_port_scheduler.sv
// Single-port scheduler in front of the 32x32 register file: arbitrates decode
// dual reads against buffered writeback writes and forwards pending write data.
module regfile_port_scheduler #(
  parameter int unsigned ADDRESS_WIDTH = 5,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned WBUF_DEPTH    = 2
) (
  input  logic                     iCLK,
  input  logic                     iRSTN,
  input  logic                     iRD_VALID,
  output logic                     oRD_READY,
  input  logic [ADDRESS_WIDTH-1:0] iRS1,
  input  logic [ADDRESS_WIDTH-1:0] iRS2,
  output logic                     oRD_DATA_VALID,
  output logic [DATA_WIDTH-1:0]    oRS1_DATA,
  output logic [DATA_WIDTH-1:0]    oRS2_DATA,
  input  logic                     iWR_VALID,
  output logic                     oWR_READY,
  input  logic [ADDRESS_WIDTH-1:0] iWR_ADDR,
  input  logic [DATA_WIDTH-1:0]    iWR_DATA,
  output logic                     oWE3,
  output logic [ADDRESS_WIDTH-1:0] oAD1,
  output logic [ADDRESS_WIDTH-1:0] oAD2,
  output logic [ADDRESS_WIDTH-1:0] oAD3,
  output logic [DATA_WIDTH-1:0]    oWD3,
  input  logic [DATA_WIDTH-1:0]    iRD1,
  input  logic [DATA_WIDTH-1:0]    iRD2
);

  localparam int unsigned CNT_W = $clog2(WBUF_DEPTH + 1);

  // Write buffer is a shift FIFO: entry 0 is the oldest (head).
  logic [ADDRESS_WIDTH-1:0] wb_addr_q [WBUF_DEPTH];
  logic [ADDRESS_WIDTH-1:0] wb_addr_d [WBUF_DEPTH];
  logic [DATA_WIDTH-1:0]    wb_data_q [WBUF_DEPTH];
  logic [DATA_WIDTH-1:0]    wb_data_d [WBUF_DEPTH];
  logic [CNT_W-1:0]         count_q, count_d;

  logic                     rd_valid_q;
  logic                     fwd_hit_q  [2];
  logic                     fwd_hit_d  [2];
  logic [DATA_WIDTH-1:0]    fwd_data_q [2];
  logic [DATA_WIDTH-1:0]    fwd_data_d [2];
  logic                     zero_q     [2];
  logic                     zero_d     [2];

  logic                     full_c, drain_c, rd_issue_c, push_c;
  logic [CNT_W-1:0]         tail_c;
  logic [ADDRESS_WIDTH-1:0] rs_c [2];

  // Port arbitration: draining wins whenever decode is idle or the buffer is full.
  assign full_c     = (count_q == CNT_W'(WBUF_DEPTH));
  assign drain_c    = (count_q != '0) && (!iRD_VALID || full_c);
  assign rd_issue_c = iRD_VALID && !full_c;
  assign push_c     = iWR_VALID && !full_c && (iWR_ADDR != '0);
  assign oRD_READY  = !full_c;
  assign oWR_READY  = !full_c;
  assign rs_c[0]    = iRS1;
  assign rs_c[1]    = iRS2;

  // Register-file port drive for the selected action.
  always_comb begin
    oWE3 = 1'b0;
    oAD1 = '0;
    oAD2 = '0;
    oAD3 = '0;
    oWD3 = '0;
    if (drain_c) begin
      oWE3 = 1'b1;
      oAD3 = wb_addr_q[0];
      oWD3 = wb_data_q[0];
    end else if (rd_issue_c) begin
      oAD1 = iRS1;
      oAD2 = iRS2;
    end
  end

  // FIFO next state: pop shifts toward the head, push lands after the survivors.
  always_comb begin
    wb_addr_d = wb_addr_q;
    wb_data_d = wb_data_q;
    tail_c    = count_q - CNT_W'(drain_c);
    if (drain_c) begin
      for (int i = 0; i < int'(WBUF_DEPTH) - 1; i++) begin
        wb_addr_d[i] = wb_addr_q[i+1];
        wb_data_d[i] = wb_data_q[i+1];
      end
    end
    for (int i = 0; i < int'(WBUF_DEPTH); i++) begin
      if (push_c && (CNT_W'(i) == tail_c)) begin
        wb_addr_d[i] = iWR_ADDR;
        wb_data_d[i] = iWR_DATA;
      end
    end
    count_d = count_q + CNT_W'(push_c) - CNT_W'(drain_c);
  end

  // Forwarding resolution per source; later matches are younger and override.
  always_comb begin
    for (int s = 0; s < 2; s++) begin
      fwd_hit_d[s]  = 1'b0;
      fwd_data_d[s] = '0;
      zero_d[s]     = (rs_c[s] == '0);
      for (int i = 0; i < int'(WBUF_DEPTH); i++) begin
        if ((CNT_W'(i) < count_q) && (wb_addr_q[i] == rs_c[s])) begin
          fwd_hit_d[s]  = 1'b1;
          fwd_data_d[s] = wb_data_q[i];
        end
      end
      if (push_c && (iWR_ADDR == rs_c[s])) begin
        fwd_hit_d[s]  = 1'b1;
        fwd_data_d[s] = iWR_DATA;
      end
    end
  end

  // Buffer and occupancy state.
  always_ff @(posedge iCLK or negedge iRSTN) begin
    if (!iRSTN) begin
      count_q <= '0;
      for (int i = 0; i < int'(WBUF_DEPTH); i++) begin
        wb_addr_q[i] <= '0;
        wb_data_q[i] <= '0;
      end
    end else begin
      count_q   <= count_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
    end
  end

  // Issue-cycle capture of the forwarding decision for the result cycle.
  always_ff @(posedge iCLK or negedge iRSTN) begin
    if (!iRSTN) begin
      rd_valid_q <= 1'b0;
      for (int s = 0; s < 2; s++) begin
        fwd_hit_q[s]  <= 1'b0;
        fwd_data_q[s] <= '0;
        zero_q[s]     <= 1'b0;
      end
    end else begin
      rd_valid_q <= rd_issue_c;
      if (rd_issue_c) begin
        fwd_hit_q  <= fwd_hit_d;
        fwd_data_q <= fwd_data_d;
        zero_q     <= zero_d;
      end
    end
  end

  // Result mux: registered decision combined with the register file's registered data.
  always_comb begin
    oRD_DATA_VALID = rd_valid_q;
    oRS1_DATA      = '0;
    oRS2_DATA      = '0;
    if (rd_valid_q) begin
      if (!zero_q[0]) oRS1_DATA = fwd_hit_q[0] ? fwd_data_q[0] : iRD1;
      if (!zero_q[1]) oRS2_DATA = fwd_hit_q[1] ? fwd_data_q[1] : iRD2;
    end
  end

endmodule

// File: tb/tb_regfile_port_scheduler.sv
// Scoreboard bench for regfile_port_scheduler with a behavioural register file.
module tb_regfile_port_scheduler;

  localparam int unsigned AW    = 5;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 3;

  logic          iCLK = 1'b0;
  logic          iRSTN;
  logic          iRD_VALID, oRD_READY;
  logic [AW-1:0] iRS1, iRS2;
  logic          oRD_DATA_VALID;
  logic [DW-1:0] oRS1_DATA, oRS2_DATA;
  logic          iWR_VALID, oWR_READY;
  logic [AW-1:0] iWR_ADDR;
  logic [DW-1:0] iWR_DATA;
  logic          oWE3;
  logic [AW-1:0] oAD1, oAD2, oAD3;
  logic [DW-1:0] oWD3;
  logic [DW-1:0] iRD1, iRD2;

  regfile_port_scheduler #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .WBUF_DEPTH(DEPTH)) dut (
    .iCLK(iCLK), .iRSTN(iRSTN),
    .iRD_VALID(iRD_VALID), .oRD_READY(oRD_READY), .iRS1(iRS1), .iRS2(iRS2),
    .oRD_DATA_VALID(oRD_DATA_VALID), .oRS1_DATA(oRS1_DATA), .oRS2_DATA(oRS2_DATA),
    .iWR_VALID(iWR_VALID), .oWR_READY(oWR_READY), .iWR_ADDR(iWR_ADDR), .iWR_DATA(iWR_DATA),
    .oWE3(oWE3), .oAD1(oAD1), .oAD2(oAD2), .oAD3(oAD3), .oWD3(oWD3),
    .iRD1(iRD1), .iRD2(iRD2)
  );

  always #5 iCLK = ~iCLK;

  typedef struct {
    logic [DW-1:0] d1;
    logic [DW-1:0] d2;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] rf   [32];
  logic [DW-1:0] arch [32];
  logic          exp_valid;
  int            n_vec, n_err;
  int            we_count, x0_we_count;
  logic          last_rd_ready, last_wr_ready, last_we;
  logic [AW-1:0] last_ad3;
  logic [DW-1:0] last_wd3;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: check last result, drive inputs, score handshakes, model the register file.
  task automatic step(input logic rv, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                      input logic wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    logic rd_fire, wr_fire;
    logic [AW-1:0] ad1, ad2;
    exp_t e;
    check_eq("rd_valid", 32'(oRD_DATA_VALID), 32'(exp_valid));
    if (exp_valid && sb.size() != 0) begin
      e = sb.pop_front();
      if (oRD_DATA_VALID) begin
        check_eq("rs1_data", oRS1_DATA, e.d1);
        check_eq("rs2_data", oRS2_DATA, e.d2);
      end
    end
    iRD_VALID = rv; iRS1 = a1; iRS2 = a2;
    iWR_VALID = wv; iWR_ADDR = wa; iWR_DATA = wd;
    #1;
    rd_fire       = rv && oRD_READY;
    wr_fire       = wv && oWR_READY;
    last_rd_ready = oRD_READY;
    last_wr_ready = oWR_READY;
    last_we       = oWE3;
    last_ad3      = oAD3;
    last_wd3      = oWD3;
    ad1 = oAD1;
    ad2 = oAD2;
    if (oWE3) begin
      we_count++;
      if (oAD3 == '0) x0_we_count++;
    end
    if (wr_fire && wa != '0) arch[wa] = wd;
    if (rd_fire) begin
      e.d1 = (a1 == '0) ? '0 : arch[a1];
      e.d2 = (a2 == '0) ? '0 : arch[a2];
      sb.push_back(e);
    end
    exp_valid = rd_fire;
    @(posedge iCLK);
    if (last_we) rf[last_ad3] = last_wd3;
    iRD1 = rf[ad1];
    iRD2 = rf[ad2];
    @(negedge iCLK);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  initial begin
    n_vec = 0; n_err = 0; we_count = 0; x0_we_count = 0; exp_valid = 1'b0;
    for (int r = 0; r < 32; r++) begin rf[r] = '0; arch[r] = '0; end
    iRSTN = 1'b0; iRD_VALID = 1'b0; iRS1 = '0; iRS2 = '0;
    iWR_VALID = 1'b0; iWR_ADDR = '0; iWR_DATA = '0; iRD1 = '0; iRD2 = '0;
    #2;
    check_eq("rst_we3", 32'(oWE3), 32'd0);
    check_eq("rst_rd_ready", 32'(oRD_READY), 32'd1);
    check_eq("rst_wr_ready", 32'(oWR_READY), 32'd1);
    check_eq("rst_rd_valid", 32'(oRD_DATA_VALID), 32'd0);
    check_eq("rst_rs1", oRS1_DATA, 32'd0);
    check_eq("rst_rs2", oRS2_DATA, 32'd0);
    repeat (2) @(negedge iCLK);
    iRSTN = 1'b1;

    // Simple write then read back through the register file.
    step(1'b0, '0, '0, 1'b1, 5'd5, 32'hDEADBEEF);
    check_eq("wr5_ready", 32'(last_wr_ready), 32'd1);
    check_eq("wr5_no_we_same_cycle", 32'(last_we), 32'd0);
    idle(1);
    check_eq("wr5_we", 32'(last_we), 32'd1);
    check_eq("wr5_ad3", 32'(last_ad3), 32'd5);
    check_eq("wr5_wd3", last_wd3, 32'hDEADBEEF);
    step(1'b1, 5'd5, 5'd0, 1'b0, '0, '0);
    idle(1);

    // Same-cycle forward.
    step(1'b1, 5'd7, 5'd0, 1'b1, 5'd7, 32'h1234);
    idle(1);
    idle(2);

    // Youngest-entry forward with both x3 entries buffered.
    step(1'b1, 5'd0, 5'd0, 1'b1, 5'd3, 32'd1);
    step(1'b1, 5'd0, 5'd0, 1'b1, 5'd3, 32'd2);
    step(1'b1, 5'd3, 5'd3, 1'b0, '0, '0);
    check_eq("young_rd_ready", 32'(last_rd_ready), 32'd1);
    idle(DEPTH + 1);
    check_eq("young_rf3", rf[3], 32'd2);

    // Full-buffer arbitration: one stall/drain cycle, then reads resume.
    for (int k = 0; k < int'(DEPTH); k++)
      step(1'b1, 5'd1, 5'd2, 1'b1, AW'(10 + k), DW'(32'hA000 + k));
    step(1'b1, 5'd10, 5'd11, 1'b1, 5'd13, 32'hB00D);
    check_eq("full_rd_ready", 32'(last_rd_ready), 32'd0);
    check_eq("full_wr_ready", 32'(last_wr_ready), 32'd0);
    check_eq("full_we", 32'(last_we), 32'd1);
    check_eq("full_ad3", 32'(last_ad3), 32'd10);
    step(1'b1, 5'd10, 5'd11, 1'b1, 5'd13, 32'hB00D);
    check_eq("resume_rd_ready", 32'(last_rd_ready), 32'd1);
    check_eq("resume_we", 32'(last_we), 32'd0);
    step(1'b1, 5'd13, 5'd12, 1'b0, '0, '0);
    idle(DEPTH + 2);

    // x0 write is accepted and discarded.
    step(1'b0, '0, '0, 1'b1, 5'd0, 32'hFFFFFFFF);
    check_eq("x0_wr_ready", 32'(last_wr_ready), 32'd1);
    idle(1);
    check_eq("x0_no_drain", 32'(last_we), 32'd0);
    step(1'b1, 5'd0, 5'd0, 1'b0, '0, '0);
    idle(1);

    // Random traffic over a small address range to stress forwarding and duplicates.
    for (int c = 0; c < 400; c++)
      step($urandom_range(0, 3) != 0, AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
           $urandom_range(0, 1) == 1, AW'($urandom_range(0, 7)), DW'($urandom));
    idle(DEPTH + 2);
    for (int r = 0; r < 32; r++) check_eq($sformatf("rf_x%0d", r), rf[r], arch[r]);

    // Reset mid-drain with two entries pending.
    step(1'b1, 5'd20, 5'd0, 1'b1, 5'd20, 32'h5555);
    step(1'b1, 5'd21, 5'd0, 1'b1, 5'd21, 32'h6666);
    check_eq("rd_valid", 32'(oRD_DATA_VALID), 32'(exp_valid));
    iRD_VALID = 1'b0; iWR_VALID = 1'b0;
    #1;
    check_eq("pre_rst_we", 32'(oWE3), 32'd1);
    iRSTN = 1'b0;
    #1;
    check_eq("mid_rst_we", 32'(oWE3), 32'd0);
    check_eq("mid_rst_rd_valid", 32'(oRD_DATA_VALID), 32'd0);
    check_eq("mid_rst_rd_ready", 32'(oRD_READY), 32'd1);
    check_eq("mid_rst_rs1", oRS1_DATA, 32'd0);
    sb.delete();
    exp_valid = 1'b0;
    for (int r = 0; r < 32; r++) arch[r] = rf[r];
    @(negedge iCLK);
    iRSTN = 1'b1;
    we_count = 0;
    idle(DEPTH + 2);
    check_eq("no_wr_after_rst", 32'(we_count), 32'd0);
    check_eq("rst_rf20", rf[20], arch[20]);
    check_eq("x0_never_written", 32'(x0_we_count), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
